// File: rtl/alu_74382_word_seq.sv
// Word-wide sequencer around one combinational 74382 4-bit ALU slice.
// Feeds the slice one nibble per cycle (LSB first) and ripples its carry through a register.
module alu_74382_word_seq #(
   parameter int WORD_W   = 16,
   parameter int SELECT_W = 3,
   parameter int NIB_W    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [SELECT_W-1:0] in_sel,
   input  logic [WORD_W-1:0]   in_a,
   input  logic [WORD_W-1:0]   in_b,
   input  logic                in_carry,
   output logic [SELECT_W-1:0] alu_sel,
   output logic [NIB_W-1:0]    alu_a,
   output logic [NIB_W-1:0]    alu_b,
   output logic                alu_cn,
   input  logic [NIB_W-1:0]    alu_f,
   input  logic                alu_ovr,
   input  logic                alu_cout,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORD_W-1:0]   out_result,
   output logic                out_carry,
   output logic                out_overflow
);

   localparam int NUM_NIB = WORD_W / NIB_W;
   localparam int CNT_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NUM_NIB - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                           state_q;
   logic [CNT_W-1:0]                 cnt_q;
   logic [CNT_W-1:0]                 cnt_d;
   logic [SELECT_W-1:0]              sel_q;
   logic [NUM_NIB-1:0][NIB_W-1:0]    a_q;
   logic [NUM_NIB-1:0][NIB_W-1:0]    b_q;
   logic [NUM_NIB-1:0][NIB_W-1:0]    res_q;
   logic                             carry_q;
   logic                             out_carry_q;
   logic                             out_ovr_q;

   assign cnt_d = cnt_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         sel_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         out_carry_q <= 1'b0;
         out_ovr_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sel_q   <= in_sel;
                  a_q     <= in_a;
                  b_q     <= in_b;
                  carry_q <= in_carry;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               // The slice carry is chained for every select code, exactly as cascaded devices would be.
               res_q[cnt_q] <= alu_f;
               carry_q      <= alu_cout;
               if (cnt_q == LAST_NIB) begin
                  out_carry_q <= alu_cout;
                  out_ovr_q   <= alu_ovr;
                  cnt_q       <= '0;
                  state_q     <= DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DONE: begin
               if (out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Slice inputs come only from registers so the slice never sees in_* directly.
   assign alu_sel = sel_q;
   assign alu_a   = (state_q == RUN) ? a_q[cnt_q] : '0;
   assign alu_b   = (state_q == RUN) ? b_q[cnt_q] : '0;
   assign alu_cn  = (state_q == RUN) ? carry_q    : 1'b0;

   assign in_ready     = (state_q == IDLE);
   assign out_valid    = (state_q == DONE);
   assign out_result   = res_q;
   assign out_carry    = out_carry_q;
   assign out_overflow = out_ovr_q;

endmodule

// File: tb/tb_alu_74382_word_seq.sv
// Directed bench for alu_74382_word_seq with a behavioural 74382 slice model on the alu_* pins.
module tb_alu_74382_word_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_sel;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        in_carry;
   logic [2:0]  alu_sel;
   logic [3:0]  alu_a;
   logic [3:0]  alu_b;
   logic        alu_cn;
   logic [3:0]  alu_f;
   logic        alu_ovr;
   logic        alu_cout;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_carry;
   logic        out_overflow;

   int n_chk = 0;
   int n_err = 0;

   logic [15:0] seq_a;
   logic [3:0]  seq_cn;
   int          early_vld;

   always #5 clk = ~clk;

   alu_74382_word_seq #(.WORD_W(16), .SELECT_W(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
      .in_a(in_a), .in_b(in_b), .in_carry(in_carry),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cn(alu_cn),
      .alu_f(alu_f), .alu_ovr(alu_ovr), .alu_cout(alu_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_carry(out_carry), .out_overflow(out_overflow)
   );

   // 74382 slice model: arithmetic ops carry/overflow from a 5-bit sum, logic ops give 0.
   logic [3:0] op1, op2;
   logic [4:0] sum5;
   always_comb begin
      op1      = 4'h0;
      op2      = 4'h0;
      sum5     = 5'h0;
      alu_f    = 4'h0;
      alu_ovr  = 1'b0;
      alu_cout = 1'b0;
      case (alu_sel)
         3'd1: begin op1 = alu_b; op2 = ~alu_a; end
         3'd2: begin op1 = alu_a; op2 = ~alu_b; end
         3'd3: begin op1 = alu_a; op2 = alu_b;  end
         default: ;
      endcase
      sum5 = {1'b0, op1} + {1'b0, op2} + {4'b0, alu_cn};
      case (alu_sel)
         3'd0: alu_f = 4'h0;
         3'd1, 3'd2, 3'd3: begin
            alu_f    = sum5[3:0];
            alu_cout = sum5[4];
            alu_ovr  = (op1[3] == op2[3]) && (sum5[3] != op1[3]);
         end
         3'd4: alu_f = alu_a ^ alu_b;
         3'd5: alu_f = alu_a | alu_b;
         3'd6: alu_f = alu_a & alu_b;
         default: alu_f = 4'hF;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Accept one operation, then sample the slice pins through the four RUN cycles.
   task automatic start_op(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b,
                           input logic c);
      @(negedge clk);
      in_sel = s; in_a = a; in_b = b; in_carry = c; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_a = ~a; in_b = ~b; in_sel = ~s; in_carry = ~c;
      early_vld = 0;
      for (int k = 0; k < 4; k++) begin
         seq_a[k*4 +: 4] = alu_a;
         seq_cn[k]       = alu_cn;
         if (out_valid || in_ready) early_vld++;
         @(posedge clk); #1;
      end
   endtask

   task automatic finish_op(input string tag);
      chk({tag, "_lat"}, early_vld, 0);
      chk({tag, "_vld"}, out_valid, 1);
      @(negedge clk); out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_drop"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic op_check(input string tag, input logic [2:0] s, input logic [15:0] a,
                           input logic [15:0] b, input logic c, input logic [15:0] er,
                           input logic ec, input logic eo);
      start_op(s, a, b, c);
      chk({tag, "_res"}, out_result, er);
      chk({tag, "_co"}, out_carry, ec);
      chk({tag, "_ovr"}, out_overflow, eo);
      finish_op(tag);
   endtask

   initial begin
      logic [15:0] held;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_sel = 3'd0; in_a = 16'h0; in_b = 16'h0; in_carry = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_ready", in_ready, 1);
      chk("rst_valid", out_valid, 0);
      chk("rst_res", out_result, 16'h0);
      chk("rst_flags", {out_carry, out_overflow}, 2'b00);
      chk("rst_alu", {alu_sel, alu_a, alu_b, alu_cn}, 12'h0);

      start_op(3'd3, 16'h1234, 16'h0000, 1'b0);
      chk("order_seq", seq_a, 16'h1234);
      chk("order_res", out_result, 16'h1234);
      chk("order_co", out_carry, 0);
      chk("idle_alu", {alu_a, alu_b, alu_cn}, 9'h0);
      chk("sel_hold", alu_sel, 3'd3);
      finish_op("order");

      start_op(3'd3, 16'hFFFF, 16'h0001, 1'b0);
      chk("ripple_cn", seq_cn, 4'b1110);
      chk("ripple_res", out_result, 16'h0000);
      chk("ripple_co", out_carry, 1);
      finish_op("ripple");

      op_check("add_ff", 3'd3, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
      op_check("amb", 3'd2, 16'h1234, 16'h0234, 1'b1, 16'h1000, 1'b1, 1'b0);
      op_check("amb_brw", 3'd2, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0);
      op_check("bma", 3'd1, 16'h0001, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b0);
      op_check("ovf", 3'd3, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      op_check("preset", 3'd7, 16'h1234, 16'h5678, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      op_check("clear", 3'd0, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b0, 1'b0);
      op_check("xor", 3'd4, 16'hF0F0, 16'hFF00, 1'b0, 16'h0FF0, 1'b0, 1'b0);
      op_check("or", 3'd5, 16'hA050, 16'h0A05, 1'b0, 16'hAA55, 1'b0, 1'b0);
      op_check("and", 3'd6, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0);

      // Back-pressure: result held for five cycles, no new request accepted meanwhile.
      start_op(3'd3, 16'h0F0F, 16'h0101, 1'b1);
      held = out_result;
      chk("bp_res", held, 16'h1011);
      for (int i = 0; i < 5; i++) begin
         chk("bp_state", {out_valid, in_ready}, 2'b10);
         chk("bp_hold", out_result, held);
         @(posedge clk); #1;
      end
      finish_op("bp");

      // Reset during nibble 2 of an ADD discards the operation.
      @(negedge clk);
      in_sel = 3'd3; in_a = 16'h1111; in_b = 16'h2222; in_carry = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("mid_nib2", alu_a, 4'h1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_ready", in_ready, 1);
      chk("mid_outs", {out_valid, out_carry, out_overflow, out_result}, 19'h0);
      chk("mid_alu", {alu_sel, alu_a, alu_b, alu_cn}, 12'h0);
      early_vld = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid) early_vld++;
         @(posedge clk); #1;
      end
      chk("mid_novld", early_vld, 0);
      op_check("post_rst", 3'd3, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/alu_74382_word_seq.md
Name: alu_74382_word_seq

Overview:
- Word-wide operation sequencer that sits directly upstream and downstream of a single combinational 74382 4-bit ALU slice.
- Accepts a WORD_W-bit operation over a valid/ready handshake. Feeds the slice one nibble per cycle, LSB nibble first, rippling the slice carry out through a register into the next nibble's carry in.
- Assembles the slice F outputs into a WORD_W result and presents it with final carry/overflow over a valid/ready handshake.
- Emulates a cascade of WORD_W/4 ripple-connected 74382 devices using one device.

Parameters:
- WORD_W, 16, operand/result width; must be a multiple of 4 and at least 4.
- SELECT_W, 3, 74382 function-select width.
- NIB_W, 4, slice operand width; fixed at 4, not to be overridden.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept an operation.
- in_sel  input  SELECT_W  74382 function select (0 CLEAR, 1 B-A, 2 A-B, 3 ADD, 4 XOR, 5 OR, 6 AND, 7 PRESET).
- in_a  input  WORD_W  operand A.
- in_b  input  WORD_W  operand B.
- in_carry  input  1  carry in applied to nibble 0 (Cn).
- alu_sel  output  SELECT_W  select driven to slice.
- alu_a  output  NIB_W  A nibble driven to slice.
- alu_b  output  NIB_W  B nibble driven to slice.
- alu_cn  output  1  Cn driven to slice.
- alu_f  input  NIB_W  slice F[3:0]; combinational response to alu_*.
- alu_ovr  input  1  slice OVR.
- alu_cout  input  1  slice Cn+4.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WORD_W  assembled F word.
- out_carry  output  1  Cn+4 of the most significant nibble.
- out_overflow  output  1  OVR of the most significant nibble.

Behaviour:
- NUM_NIB = WORD_W/4. Nibble counter width is clog2(NUM_NIB), minimum 1 bit.
- FSM states: IDLE, RUN, DONE.
- Reset (any state, including mid-RUN or mid-DONE):
  - state IDLE, counter 0, operand/result registers 0, carry register 0.
  - in_ready=1, out_valid=0, out_result=0, out_carry=0, out_overflow=0.
  - alu_sel=0, alu_a=0, alu_b=0, alu_cn=0.
  - Any in-flight operation is discarded; no output is produced for it.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register sel, A, B; load carry register with in_carry; counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - In cycle k (k=0..NUM_NIB-1), drive all slice inputs from registers only, never combinationally from in_*:
    - alu_sel = registered sel.
    - alu_a = A[4k+3:4k], alu_b = B[4k+3:4k].
    - alu_cn = carry register.
  - At the edge ending cycle k:
    - result[4k+3:4k] <= alu_f.
    - carry register <= alu_cout.
    - counter increments.
  - At k=NUM_NIB-1: out_carry <= alu_cout, out_overflow <= alu_ovr, go to DONE.
- Carry is chained for every select code, including logic, CLEAR and PRESET, exactly as wired devices would. Carry polarity is the 74382's native polarity: for subtraction, Cn=1 means no borrow. No inversion is applied.
- alu_a/alu_b/alu_cn are 0 outside RUN. alu_sel holds the last registered sel.
- DONE:
  - out_valid=1; out_result/out_carry/out_overflow held stable until handshake.
  - On out_valid&&out_ready: out_valid drops next cycle, go to IDLE.
  - in_ready stays 0 in DONE, including the handshake cycle. A new request is accepted at the earliest on the first IDLE cycle.
- Latency: accept edge to out_valid rising = NUM_NIB+1 edges (out_valid high NUM_NIB cycles after the accept cycle).
- Minimum period between accepts: NUM_NIB+2 cycles.
- in_* inputs are ignored outside IDLE. Changing them during RUN has no effect.
- WORD_W=4 degenerates to a single RUN cycle.

Test Plan:
- Nibble ordering: sel=3, A=0x1234, B=0x0000, Cn=0 -> alu_a sequence 0x4,0x3,0x2,0x1 in consecutive RUN cycles; out_result=0x1234, out_carry=0.
- Carry ripple: sel=3, A=0xFFFF, B=0x0001, Cn=0 -> alu_cn sequence 0,1,1,1; out_result=0x0000, out_carry=1. Same A/B with A=0x00FF -> out_result=0x0100, out_carry=0.
- Subtract and overflow:
  - sel=2, A=0x1234, B=0x0234, Cn=1 -> out_result=0x1000, out_carry=1.
  - sel=3, A=0x7FFF, B=0x0001, Cn=0 -> out_result=0x8000, out_overflow=1.
- Logic/constant ops: sel=7, any A/B, Cn=0 -> out_result=0xFFFF; sel=0 -> out_result=0x0000.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and outputs stable, in_ready=0. Raise out_ready -> out_valid=0 next cycle, in_ready=1.
- Reset mid-RUN: assert rst during nibble 2 of an ADD -> next cycle in IDLE with all outputs at reset values. out_valid never asserts for the aborted operation; the next operation completes correctly.
